// File: rtl/serial_deserializer.sv
// serial_deserializer: start-bit framed MSB-first serial receiver with a one-word valid/ready output buffer.
module serial_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in,
  input  logic             io_in_valid,
  output logic [WIDTH-1:0] io_out_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic             io_busy,
  output logic             io_overrun
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             consume;
  assign word    = {shreg[WIDTH-2:0], io_in};
  assign done    = state == SHIFT && io_in_valid && cnt == CW'(WIDTH - 1);
  assign consume = io_out_valid && io_out_ready;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      io_out_bits  <= '0;
      io_out_valid <= 1'b0;
      io_busy      <= 1'b0;
      io_overrun   <= 1'b0;
    end else begin
      io_overrun <= 1'b0;
      if (consume) io_out_valid <= 1'b0;
      if (state == IDLE && io_in_valid && io_in) begin
        state   <= SHIFT;
        cnt     <= '0;
        io_busy <= 1'b1;
      end
      if (state == SHIFT && io_in_valid) begin
        shreg <= word;
        cnt   <= done ? '0 : cnt + 1'b1;
      end
      // Completion loads from the live bit, not the stale shreg
      if (done) begin
        state   <= IDLE;
        io_busy <= 1'b0;
        if (!io_out_valid || consume) begin
          io_out_bits  <= word;
          io_out_valid <= 1'b1;
        end else begin
          io_overrun <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Receive end of the single-bit serial link carried by the `ShiftRegister` datapath.
- Detects a start bit, shifts in WIDTH data bits MSB-first, and presents each completed word on a one-entry parallel output buffer with a valid/ready handshake.
- Flags words lost because the output buffer was still occupied.
- Sits between the serial link and word-wide consumers in the basic examples set.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..64.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- io_in  input  1  serial data bit.
- io_in_valid  input  1  io_in carries a link bit this cycle.
- io_out_bits  output  WIDTH  received word, MSB = first data bit received.
- io_out_valid  output  1  io_out_bits holds an unconsumed word.
- io_out_ready  input  1  consumer accepts the word this cycle.
- io_busy  output  1  high while in SHIFT state.
- io_overrun  output  1  one-cycle pulse: a completed word was discarded.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, bit counter=0, shift register=0, io_out_bits=0, io_out_valid=0, io_busy=0, io_overrun=0. Reset mid-frame abandons the partial word; a pending output word is also lost. After release, the first edge with reset=1 starts in IDLE.
- Bit accept: a link bit is consumed only on an edge where io_in_valid=1. Cycles with io_in_valid=0 leave state, counter and shift register unchanged, in any state.
- IDLE:
  - io_in_valid=1 and io_in=1 (start bit) -> SHIFT; counter=0; io_busy=1 from the next cycle.
  - io_in=0 with io_in_valid=1 is line idle and is ignored.
- SHIFT:
  - Each accepted bit updates shreg = {shreg[WIDTH-2:0], io_in} and increments the counter.
  - The accept that makes counter reach WIDTH completes the frame. On that edge, state -> IDLE and counter -> 0.
  - The completed word is {shreg[WIDTH-2:0], io_in}; a stale shreg value must not be used.
  - No stop bit. A start bit may be accepted on the very next cycle after completion.
- Output buffer:
  - A word is consumed on an edge with io_out_valid=1 and io_out_ready=1. io_out_valid then clears unless a new word loads on the same edge.
  - On frame completion, the word loads if the buffer is empty or is being consumed on that same edge. In that case io_out_bits=word and io_out_valid=1 from the next cycle. Latency: valid is visible the cycle after the edge that accepted the last data bit.
  - If the buffer is full and not consumed on the completion edge, the new word is discarded and io_overrun=1 for exactly the next cycle. The buffered word is unchanged.
  - io_out_bits is stable while io_out_valid=1 and not consumed. io_out_ready is ignored while io_out_valid=0.
- Widths:
  - Counter width is clog2(WIDTH+1).
  - The counter never exceeds WIDTH.
  - io_overrun is 0 on every cycle except the pulse cycle.
- Simultaneous consume and completion on the same edge: the new word is loaded, io_out_valid stays 1, and there is no overrun.

Test Plan:
- WIDTH=8; after reset, drive io_in_valid=1 with bits 1 (start) then 1,0,1,0,0,1,0,1 on consecutive cycles, io_out_ready=0 -> the cycle after the last bit: io_out_valid=1, io_out_bits=0xA5, io_busy=0, io_overrun=0; the values hold until io_out_ready=1.
- Same frame 0x3C with io_in_valid=0 inserted for 3 cycles after the 4th data bit -> io_out_bits=0x3C; io_busy stays 1 through the gap; completion is delayed exactly 3 cycles.
- Buffer holds 0xA5 with io_out_ready=0; send frame 0x5A -> io_overrun=1 for one cycle; io_out_bits remains 0xA5.
- Buffer holds 0xA5; send 0x5A with io_out_ready=1 only on the completion edge -> no overrun; next cycle io_out_valid=1, io_out_bits=0x5A.
- io_in_valid=1 with io_in=0 for 20 cycles in IDLE -> io_busy=0, io_out_valid=0 throughout.
- Assert reset=0 asynchronously after 4 data bits, release, then send full frame 0xFF -> only 0xFF appears; no partial word is ever output; all outputs read 0 during reset.
